// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, FSM state encoding and parity helper shared by the UART
// Contents: par_mode_t (NONE/ODD/EVEN), uart_state_t (TX and RX FSM states),
//           parity_bit() returning the parity bit for up to 8 data bits.
package uart_pkg;
    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} par_mode_t;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;
    // Narrower data is zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [7:0] data, input par_mode_t mode);
        return mode == PAR_ODD ? ~^data : ^data;
    endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: receive FIFO holding {perr, ferr, data} entries
// Ports: inclk/rst_n clock and async active-low reset; wr/wdata push;
//        rd pop strobe; rdata head entry (zero when empty); rdy not-empty;
//        ovf pulses when a push is dropped because the FIFO is full.
module uart_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             inclk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             rdy,
    output logic             ovf
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic do_rd, do_wr;
    assign rdy   = count != '0;
    assign do_rd = rd && rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign do_wr = wr && (count != (AW+1)'(DEPTH) || do_rd);
    assign ovf   = wr && !do_wr;
    assign rdata = rdy ? mem[rptr] : '0;
    always_ff @(posedge inclk) begin
        if (do_wr) mem[wptr] <= wdata;
    end
    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_wr);
            rptr  <= rptr + AW'(do_rd);
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/uart_param.sv
// uart_param: parameterised UART transmitter and receiver with receive FIFO
// Ports: inclk/rst_n clock and async active-low reset;
//        tx_data/tx_req/tx_ack/tx_busy/txd transmit handshake and serial out;
//        rxd serial in, loopback routes txd to the receiver;
//        rx_data/rx_perr/rx_ferr FIFO head, rx_rdy not-empty, rx_ack pop,
//        rx_ovf pulses when a received frame is dropped.
module uart_param
    import uart_pkg::*;
#(
    parameter int    DATA_BITS     = 8,
    parameter string PARITY        = "ODD",
    parameter int    STOP_BITS     = 1,
    parameter int    BAUD_DIV      = 16,
    parameter int    RX_FIFO_DEPTH = 4
) (
    input  logic                 inclk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_req,
    output logic                 tx_ack,
    output logic                 tx_busy,
    output logic                 txd,
    input  logic                 rxd,
    input  logic                 loopback,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_rdy,
    input  logic                 rx_ack,
    output logic                 rx_ovf
);
    localparam par_mode_t MODE = PARITY == "NONE" ? PAR_NONE : PARITY == "EVEN" ? PAR_EVEN : PAR_ODD;
    localparam bit HAS_PAR = MODE != PAR_NONE;
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

    uart_state_t tx_state, tx_next, rx_state, rx_next;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [2:0] tx_idx, rx_idx, sync;
    logic [DATA_BITS-1:0] tx_sh, rx_sh;
    logic [DATA_BITS+1:0] rx_head;
    logic tx_par, tx_tick, rx_samp, rx_line, rx_fall, rx_wr, rx_perr_q;

    assign tx_tick = tx_cnt == LAST;
    assign tx_busy = tx_state != S_IDLE;

    always_comb begin
        tx_next = tx_state;
        tx_ack  = 1'b0;
        case (tx_state)
            S_IDLE:   if (tx_req) begin
                tx_ack  = 1'b1;
                tx_next = S_START;
            end
            S_START:  if (tx_tick) tx_next = S_DATA;
            S_DATA:   if (tx_tick && tx_idx == 3'(DATA_BITS - 1)) tx_next = HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (tx_tick) tx_next = S_STOP;
            // A request pending at the end of the stop time starts the next frame with no idle bit.
            S_STOP:   if (tx_tick && tx_idx == 3'(STOP_BITS - 1)) begin
                tx_ack  = tx_req;
                tx_next = tx_req ? S_START : S_IDLE;
            end
            default:  tx_next = S_IDLE;
        endcase
        txd = tx_state == S_START ? 1'b0 : tx_state == S_DATA ? tx_sh[0] : tx_state == S_PARITY ? tx_par : 1'b1;
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            if (tx_tick) tx_idx <= tx_next != tx_state ? '0 : tx_idx + 1'b1;
            if (tx_ack) begin
                tx_sh  <= tx_data;
                tx_par <= parity_bit(8'(tx_data), MODE);
            end else if (tx_state == S_DATA && tx_tick) begin
                tx_sh <= tx_sh >> 1;
            end
        end
    end

    // sync[1:0] is the synchroniser; sync[2] keeps the previous value for start-edge detection.
    assign rx_line = sync[1];
    assign rx_fall = sync[2] && !sync[1];
    // The counter free-runs from the start edge, so the mid-start sample and every later
    // sample share one compare point spaced BAUD_DIV apart.
    assign rx_samp = rx_cnt == HALF;
    assign rx_wr   = rx_state == S_STOP && rx_samp;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:   if (rx_fall) rx_next = S_START;
            S_START:  if (rx_samp) rx_next = rx_line ? S_IDLE : S_DATA;
            S_DATA:   if (rx_samp && rx_idx == 3'(DATA_BITS - 1)) rx_next = HAS_PAR ? S_PARITY : S_STOP;
            S_PARITY: if (rx_samp) rx_next = S_STOP;
            S_STOP:   if (rx_samp) rx_next = S_IDLE;
            default:  rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= '1;
            rx_state  <= S_IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_sh     <= '0;
            rx_perr_q <= 1'b0;
        end else begin
            sync     <= {sync[1:0], loopback ? txd : rxd};
            rx_state <= rx_next;
            rx_cnt   <= (rx_state == S_IDLE || rx_cnt == LAST) ? '0 : rx_cnt + 1'b1;
            if (rx_samp) rx_idx <= rx_state == S_DATA ? rx_idx + 1'b1 : '0;
            if (rx_samp && rx_state == S_DATA) rx_sh <= {rx_line, rx_sh[DATA_BITS-1:1]};
            if (rx_state == S_IDLE) rx_perr_q <= 1'b0;
            else if (rx_samp && rx_state == S_PARITY) rx_perr_q <= rx_line != parity_bit(8'(rx_sh), MODE);
        end
    end

    uart_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(RX_FIFO_DEPTH)) u_fifo (
        .inclk (inclk),
        .rst_n (rst_n),
        .wr    (rx_wr),
        .wdata ({rx_perr_q, ~rx_line, rx_sh}),
        .rd    (rx_ack),
        .rdata (rx_head),
        .rdy   (rx_rdy),
        .ovf   (rx_ovf)
    );
    assign {rx_perr, rx_ferr, rx_data} = rx_head;
endmodule
